// File: rtl/words_pos_sequencer_pkg.sv
// words_pkg: shared definitions for the words/POS trellis sequencer.
//   phase_t      : phase encoding, also driven onto phase_o
//   *_DEF        : default sentence-length and POS-count dimensions
package words_pkg;

    localparam int unsigned WORD_NUM_DEF     = 16;
    localparam int unsigned WORD_NUM_BIT_DEF = 4;
    localparam int unsigned POS_NUM_DEF      = 11;
    localparam int unsigned POS_NUM_BIT_DEF  = 4;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_INIT  = 3'd1,
        PH_RECUR = 3'd2,
        PH_TERM  = 3'd3,
        PH_BACK  = 3'd4,
        PH_DONE  = 3'd5
    } phase_t;

endpackage

// File: rtl/words_pos_sequencer_pos_wrap_counter.sv
// pos_wrap_counter: counts 0..CNT_MAX-1 and wraps back to 0.
//   clk, reset_Words_control : clock, async active-low reset
//   clr      : synchronous clear to 0 (priority over en)
//   en       : advance by one, wrapping after CNT_MAX-1
//   cnt      : registered count
//   cnt_next : value cnt takes at the next edge
//   tc       : cnt is at CNT_MAX-1
module pos_wrap_counter
    import words_pkg::*;
#(
    parameter int unsigned CNT_MAX = POS_NUM_DEF,
    parameter int unsigned CNT_BIT = POS_NUM_BIT_DEF
) (
    input  logic               clk,
    input  logic               reset_Words_control,
    input  logic               clr,
    input  logic               en,
    output logic [CNT_BIT-1:0] cnt,
    output logic [CNT_BIT-1:0] cnt_next,
    output logic               tc
);

    localparam logic [CNT_BIT-1:0] CNT_LAST = CNT_BIT'(CNT_MAX - 1);

    assign tc = (cnt == CNT_LAST);

    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = tc ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_Words_control) begin
        if (!reset_Words_control) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/words_pos_sequencer.sv
// words_pos_sequencer: Viterbi loop-nest sequencer (word t, state j, prev i)
// walking INIT -> RECUR -> TERM -> BACK for a programmable sentence length.
//   clk, reset_Words_control : clock, async active-low reset
//   start_i, sent_len_i      : start request with sentence length (IDLE only)
//   advance_i                : consumer accepts current index set (0 = stall)
//   word_o, pos_cur_o, pos_prev_o : current t, j, i
//   phase_o                  : current phase (phase_t encoding)
//   valid_o                  : index set is meaningful
//   first_prev_o/last_prev_o : RECUR with i == 0 / i == POS_num-1
//   busy_o, done_o, err_o    : not idle / completion pulse / rejected start pulse
module words_pos_sequencer
    import words_pkg::*;
#(
    parameter int unsigned word_num     = WORD_NUM_DEF,
    parameter int unsigned word_num_bit = WORD_NUM_BIT_DEF,
    parameter int unsigned POS_num      = POS_NUM_DEF,
    parameter int unsigned POS_num_bit  = POS_NUM_BIT_DEF
) (
    input  logic                    clk,
    input  logic                    reset_Words_control,
    input  logic                    start_i,
    input  logic [word_num_bit:0]   sent_len_i,
    input  logic                    advance_i,
    output logic [word_num_bit-1:0] word_o,
    output logic [POS_num_bit-1:0]  pos_cur_o,
    output logic [POS_num_bit-1:0]  pos_prev_o,
    output logic [2:0]              phase_o,
    output logic                    valid_o,
    output logic                    first_prev_o,
    output logic                    last_prev_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int unsigned         LEN_W    = word_num_bit + 1;
    localparam logic [LEN_W-1:0]    LEN_MAX  = LEN_W'(word_num);
    localparam logic [LEN_W-1:0]    LEN_ONE  = LEN_W'(1);
    localparam logic [POS_num_bit-1:0] POS_LAST = POS_num_bit'(POS_num - 1);

    phase_t                  state_q, state_d;
    logic [word_num_bit-1:0] t_q, t_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    err_d;
    logic                    step;
    logic                    len_ok;
    logic                    t_at_last;

    logic                    i_clr, i_en, i_tc;
    logic                    j_clr, j_en, j_tc;
    logic [POS_num_bit-1:0]  i_cnt, i_nxt, j_cnt, j_nxt;

    assign step      = valid_o & advance_i;
    assign len_ok    = (sent_len_i != '0) && (sent_len_i <= LEN_MAX);
    assign t_at_last = ({1'b0, t_q} == (len_q - LEN_ONE));

    assign word_o     = t_q;
    assign pos_cur_o  = j_cnt;
    assign pos_prev_o = i_cnt;
    assign phase_o    = state_q;

    pos_wrap_counter #(
        .CNT_MAX (POS_num),
        .CNT_BIT (POS_num_bit)
    ) u_prev_cnt (
        .clk                 (clk),
        .reset_Words_control (reset_Words_control),
        .clr                 (i_clr),
        .en                  (i_en),
        .cnt                 (i_cnt),
        .cnt_next            (i_nxt),
        .tc                  (i_tc)
    );

    pos_wrap_counter #(
        .CNT_MAX (POS_num),
        .CNT_BIT (POS_num_bit)
    ) u_cur_cnt (
        .clk                 (clk),
        .reset_Words_control (reset_Words_control),
        .clr                 (j_clr),
        .en                  (j_en),
        .cnt                 (j_cnt),
        .cnt_next            (j_nxt),
        .tc                  (j_tc)
    );

    // The counters wrap to 0 on their own, so every phase exit that needs
    // j = 0 / i = 0 gets it from the wrap rather than an explicit clear.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        len_d   = len_q;
        err_d   = 1'b0;
        i_clr   = 1'b0;
        i_en    = 1'b0;
        j_clr   = 1'b0;
        j_en    = 1'b0;
        unique case (state_q)
            PH_IDLE: begin
                i_clr = 1'b1;
                j_clr = 1'b1;
                t_d   = '0;
                if (start_i) begin
                    if (len_ok) begin
                        len_d   = sent_len_i;
                        state_d = PH_INIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PH_INIT: begin
                if (step) begin
                    j_en = 1'b1;
                    if (j_tc) begin
                        if (len_q == LEN_ONE) begin
                            state_d = PH_TERM;
                        end else begin
                            state_d = PH_RECUR;
                            t_d     = word_num_bit'(1);
                        end
                    end
                end
            end
            PH_RECUR: begin
                if (step) begin
                    i_en = 1'b1;
                    if (i_tc) begin
                        j_en = 1'b1;
                        if (j_tc) begin
                            if (t_at_last) begin
                                state_d = PH_TERM;
                            end else begin
                                t_d = t_q + 1'b1;
                            end
                        end
                    end
                end
            end
            PH_TERM: begin
                if (step) begin
                    j_en = 1'b1;
                    if (j_tc) begin
                        state_d = (len_q > LEN_ONE) ? PH_BACK : PH_DONE;
                    end
                end
            end
            PH_BACK: begin
                if (step) begin
                    t_d = t_q - 1'b1;
                    if (t_q == word_num_bit'(1)) begin
                        state_d = PH_DONE;
                    end
                end
            end
            PH_DONE: begin
                i_clr   = 1'b1;
                j_clr   = 1'b1;
                t_d     = '0;
                state_d = PH_IDLE;
            end
            default: begin
                state_d = PH_IDLE;
            end
        endcase
    end

    // Status flags are registered from next-state values so they line up
    // with the registered indices they describe.
    always_ff @(posedge clk or negedge reset_Words_control) begin
        if (!reset_Words_control) begin
            state_q      <= PH_IDLE;
            t_q          <= '0;
            len_q        <= '0;
            valid_o      <= 1'b0;
            first_prev_o <= 1'b0;
            last_prev_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            len_q        <= len_d;
            valid_o      <= state_d inside {PH_INIT, PH_RECUR, PH_TERM, PH_BACK};
            first_prev_o <= (state_d == PH_RECUR) && (i_nxt == '0);
            last_prev_o  <= (state_d == PH_RECUR) && (i_nxt == POS_LAST);
            busy_o       <= (state_d != PH_IDLE);
            done_o       <= (state_d == PH_DONE);
            err_o        <= err_d;
        end
    end

endmodule

// File: tb/tb_words_pos_sequencer.sv
// Testbench for words_pos_sequencer: table-driven start/reject vectors,
// full-run / stall / random runs against a loop-nest reference model,
// and an abort-by-reset sequence.
module tb_words_pos_sequencer;

    localparam int WN = 16;
    localparam int WB = 4;
    localparam int PN = 11;
    localparam int PB = 4;

    logic          clk = 1'b0;
    logic          reset_Words_control = 1'b0;
    logic          start_i = 1'b0;
    logic [WB:0]   sent_len_i = '0;
    logic          advance_i = 1'b0;
    logic [WB-1:0] word_o;
    logic [PB-1:0] pos_cur_o;
    logic [PB-1:0] pos_prev_o;
    logic [2:0]    phase_o;
    logic          valid_o, first_prev_o, last_prev_o, busy_o, done_o, err_o;

    always #5 clk = ~clk;

    words_pos_sequencer #(
        .word_num     (WN),
        .word_num_bit (WB),
        .POS_num      (PN),
        .POS_num_bit  (PB)
    ) dut (
        .clk                 (clk),
        .reset_Words_control (reset_Words_control),
        .start_i             (start_i),
        .sent_len_i          (sent_len_i),
        .advance_i           (advance_i),
        .word_o              (word_o),
        .pos_cur_o           (pos_cur_o),
        .pos_prev_o          (pos_prev_o),
        .phase_o             (phase_o),
        .valid_o             (valid_o),
        .first_prev_o        (first_prev_o),
        .last_prev_o         (last_prev_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .err_o               (err_o)
    );

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int ph;
        int t;
        int j;
        int i;
        bit first;
        bit last;
    } ref_t;

    ref_t exp_q[$];

    typedef struct {
        bit start;
        int len;
        bit exp_err;
        bit exp_busy;
        int exp_ph;
        bit exp_valid;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // {phase, t, j, i, first, last, valid, busy, done, err}
    function automatic logic [20:0] pack(input int ph, input int t, input int j, input int i,
                                         input bit f, input bit l, input bit v, input bit b,
                                         input bit d, input bit e);
        logic [2:0]    p3;
        logic [WB-1:0] t4;
        logic [PB-1:0] j4, i4;
        p3 = ph[2:0];
        t4 = t[WB-1:0];
        j4 = j[PB-1:0];
        i4 = i[PB-1:0];
        return {p3, t4, j4, i4, f, l, v, b, d, e};
    endfunction

    function automatic logic [20:0] act_vec();
        return {phase_o, word_o, pos_cur_o, pos_prev_o, first_prev_o, last_prev_o,
                valid_o, busy_o, done_o, err_o};
    endfunction

    function automatic int exp_cnt(input int L);
        return 2 * PN + (L - 1) * PN * PN + (L - 1);
    endfunction

    // Reference trellis walk: the index sets in the order they are consumed.
    task automatic build_ref(input int L);
        ref_t r;
        exp_q.delete();
        for (int j = 0; j < PN; j++) begin
            r = '{1, 0, j, 0, 1'b0, 1'b0};
            exp_q.push_back(r);
        end
        for (int t = 1; t < L; t++)
            for (int j = 0; j < PN; j++)
                for (int i = 0; i < PN; i++) begin
                    r = '{2, t, j, i, (i == 0), (i == PN - 1)};
                    exp_q.push_back(r);
                end
        for (int j = 0; j < PN; j++) begin
            r = '{3, L - 1, j, 0, 1'b0, 1'b0};
            exp_q.push_back(r);
        end
        for (int t = L - 1; t >= 1; t--) begin
            r = '{4, t, 0, 0, 1'b0, 1'b0};
            exp_q.push_back(r);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, idle.
    task automatic run_seq(input int L, input bit stall, input bit poke,
                           output int steps, output int done_cyc);
        ref_t h;
        int   cyc;
        bit   fin;
        build_ref(L);
        steps    = 0;
        done_cyc = 0;
        fin      = 1'b0;
        cyc      = 0;
        start_i    = 1'b1;
        sent_len_i = L[WB:0];
        advance_i  = 1'b0;
        while (!fin && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                chk($sformatf("idx L=%0d cyc=%0d", L, cyc), act_vec(),
                    pack(h.ph, h.t, h.j, h.i, h.first, h.last, 1'b1, 1'b1, 1'b0, 1'b0));
                advance_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (advance_i) begin
                    void'(exp_q.pop_front());
                    steps++;
                end
                start_i    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
                sent_len_i = poke ? 5'($urandom_range(0, 31)) : L[WB:0];
            end else begin
                chk($sformatf("done L=%0d", L), act_vec(),
                    pack(5, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
                start_i   = 1'b0;
                advance_i = 1'b0;
                done_cyc  = cyc;
                fin       = 1'b1;
            end
        end
        chk($sformatf("finished L=%0d", L), {63'd0, fin}, 64'd1);
        start_i = 1'b0;
        @(negedge clk);
        chk($sformatf("idle after L=%0d", L), act_vec(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic do_reset(input int cycles);
        start_i   = 1'b0;
        advance_i = 1'b0;
        reset_Words_control = 1'b0;
        #1;
        chk("reset immediate", act_vec(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (cycles) @(negedge clk);
        chk("reset held", act_vec(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset_Words_control = 1'b1;
    endtask

    vec_t vt[7];
    int   steps, done_cyc, guard;
    bit   hit;

    initial begin
        vt[0] = '{1'b1, 0,  1'b1, 1'b0, 0, 1'b0};
        vt[1] = '{1'b1, 17, 1'b1, 1'b0, 0, 1'b0};
        vt[2] = '{1'b1, 31, 1'b1, 1'b0, 0, 1'b0};
        vt[3] = '{1'b0, 5,  1'b0, 1'b0, 0, 1'b0};
        vt[4] = '{1'b1, 1,  1'b0, 1'b1, 1, 1'b1};
        vt[5] = '{1'b1, 16, 1'b0, 1'b1, 1, 1'b1};
        vt[6] = '{1'b1, 9,  1'b0, 1'b1, 1, 1'b1};

        // Reset held for 3 cycles from time zero.
        repeat (3) @(negedge clk);
        chk("reset state", act_vec(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset_Words_control = 1'b1;
        @(negedge clk);
        chk("idle after release", act_vec(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Start / reject vectors.
        for (int k = 0; k < 7; k++) begin
            start_i    = vt[k].start;
            sent_len_i = vt[k].len[WB:0];
            advance_i  = 1'b0;
            @(negedge clk);
            start_i = 1'b0;
            chk($sformatf("vec%0d", k), act_vec(),
                pack(vt[k].exp_ph, 0, 0, 0, 0, 0, vt[k].exp_valid, vt[k].exp_busy, 0, vt[k].exp_err));
            @(negedge clk);
            chk($sformatf("vec%0d next", k), act_vec(),
                pack(vt[k].exp_ph, 0, 0, 0, 0, 0, vt[k].exp_valid, vt[k].exp_busy, 0, 0));
            if (vt[k].exp_busy) begin
                do_reset(1);
                @(negedge clk);
            end
        end

        // Full run, with random start pokes while busy.
        run_seq(16, 1'b0, 1'b1, steps, done_cyc);
        chk("count L=16", steps, exp_cnt(16));
        chk("count L=16 abs", steps, 1852);

        // Shortest sentence.
        run_seq(1, 1'b0, 1'b0, steps, done_cyc);
        chk("count L=1", steps, 22);
        chk("done cycle L=1", done_cyc, 23);

        // Stalls.
        run_seq(3, 1'b1, 1'b0, steps, done_cyc);
        chk("count L=3 stall", steps, exp_cnt(3));

        for (int r = 0; r < 4; r++) begin
            int L;
            L = $urandom_range(1, 6);
            run_seq(L, 1'b1, 1'b1, steps, done_cyc);
            chk($sformatf("count rand L=%0d", L), steps, exp_cnt(L));
        end

        // Abort in RECUR at t=2.
        start_i    = 1'b1;
        sent_len_i = 5'd3;
        hit        = 1'b0;
        guard      = 0;
        @(negedge clk);
        start_i   = 1'b0;
        advance_i = 1'b1;
        while (!hit && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (phase_o == 3'd2 && word_o == 4'd2) hit = 1'b1;
        end
        chk("abort reached t=2", {63'd0, hit}, 64'd1);
        #2;
        do_reset(2);
        @(negedge clk);
        chk("after abort", act_vec(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_seq(2, 1'b0, 1'b0, steps, done_cyc);
        chk("count L=2 after abort", steps, 144);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
